// File: rtl/multi_wave_gen_pkg.sv
// Shared definitions for the multi-channel waveform generator: config select codes,
// MODE bit positions, channel sequencer states and a channel-index width helper.
package multi_wave_gen_pkg;

    localparam logic [1:0] CFG_PERIOD = 2'd0;
    localparam logic [1:0] CFG_HIGH   = 2'd1;
    localparam logic [1:0] CFG_PHASE  = 2'd2;
    localparam logic [1:0] CFG_MODE   = 2'd3;

    localparam int MODE_ONESHOT_BIT = 0;
    localparam int MODE_INVERT_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_wave_gen_chan.sv
// One waveform channel: double-buffered config, IDLE/RUN/DONE sequencer, counter and
// registered wave/busy outputs.
module multi_wave_gen_chan
    import multi_wave_gen_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter bit REPORT_WRAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             wave_o,
    output logic             busy_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] sh_period_q, sh_period_d, sh_high_q, sh_high_d, sh_phase_q, sh_phase_d;
    logic [1:0]       sh_mode_q, sh_mode_d;
    logic [CNT_W-1:0] act_period_q, act_period_d, act_high_q, act_high_d, act_phase_q, act_phase_d;
    logic [1:0]       act_mode_q, act_mode_d;
    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d, busy_q, busy_d;
    logic             wrap_s, load_s;

    // Shadow register writes.
    always_comb begin
        sh_period_d = sh_period_q;
        sh_high_d   = sh_high_q;
        sh_phase_d  = sh_phase_q;
        sh_mode_d   = sh_mode_q;
        if (cfg_we) begin
            case (cfg_sel)
                CFG_PERIOD: sh_period_d = cfg_data;
                CFG_HIGH:   sh_high_d   = cfg_data;
                CFG_PHASE:  sh_phase_d  = cfg_data;
                CFG_MODE:   sh_mode_d   = cfg_data[1:0];
                default:    sh_mode_d   = sh_mode_q;
            endcase
        end else begin
            sh_mode_d = sh_mode_q;
        end
    end

    // Active set follows the shadow (including a same-cycle write) when idle or at wrap.
    always_comb begin
        wrap_s = (state_q == ST_RUN) && (cnt_q == (act_period_q - CNT_W'(1)));
        load_s = (state_q != ST_RUN) || wrap_s;
        if (load_s) begin
            act_period_d = sh_period_d;
            act_high_d   = sh_high_d;
            act_phase_d  = sh_phase_d;
            act_mode_d   = sh_mode_d;
        end else begin
            act_period_d = act_period_q;
            act_high_d   = act_high_q;
            act_phase_d  = act_phase_q;
            act_mode_d   = act_mode_q;
        end
    end

    // Sequencer and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (act_period_q != '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = (act_phase_q < act_period_q) ? act_phase_q : '0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wrap_s) begin
                    cnt_d = '0;
                    if (act_period_d == '0) begin
                        state_d = ST_IDLE;
                    end else if (act_mode_q[MODE_ONESHOT_BIT]) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the next cycle, computed from the next counter state.
    always_comb begin
        wave_d = ((state_d == ST_RUN) && (cnt_d < act_high_d)) ^ act_mode_d[MODE_INVERT_BIT];
        busy_d = (state_d == ST_RUN);
        if (REPORT_WRAP) begin
            wrap_o = wrap_s;
        end else begin
            wrap_o = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_period_q  <= '0;
            sh_high_q    <= '0;
            sh_phase_q   <= '0;
            sh_mode_q    <= 2'b00;
            act_period_q <= '0;
            act_high_q   <= '0;
            act_phase_q  <= '0;
            act_mode_q   <= 2'b00;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wave_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sh_period_q  <= sh_period_d;
            sh_high_q    <= sh_high_d;
            sh_phase_q   <= sh_phase_d;
            sh_mode_q    <= sh_mode_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            act_phase_q  <= act_phase_d;
            act_mode_q   <= act_mode_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wave_q       <= wave_d;
            busy_q       <= busy_d;
        end
    end

    assign wave_o = wave_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-channel rectangular waveform generator: decodes config writes to channels and
// registers the channel-0 wrap as sync_pulse.
module multi_wave_gen
    import multi_wave_gen_pkg::*;
#(
    parameter  int CHANNELS = 3,
    parameter  int CNT_W    = 8,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_sel,
    input  logic [CNT_W-1:0]    cfg_data,
    output logic [CHANNELS-1:0] wave_out,
    output logic [CHANNELS-1:0] busy,
    output logic                sync_pulse
);

    logic [CHANNELS-1:0] ch_we_s;
    logic [CHANNELS-1:0] wrap_s;
    logic                sync_q, sync_d;

    // Channel select; indices at or beyond CHANNELS match nothing.
    always_comb begin
        ch_we_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                ch_we_s[i] = 1'b1;
            end else begin
                ch_we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        multi_wave_gen_chan #(
            .CNT_W       (CNT_W),
            .REPORT_WRAP (g == 0)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable),
            .cfg_we   (ch_we_s[g]),
            .cfg_sel  (cfg_sel),
            .cfg_data (cfg_data),
            .wave_o   (wave_out[g]),
            .busy_o   (busy[g]),
            .wrap_o   (wrap_s[g])
        );
    end

    // Only channel 0 reports its wrap, so the reduction is channel 0's wrap.
    always_comb begin
        sync_d = |wrap_s;
    end

    // Sync pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_pulse = sync_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Directed self-checking bench for multi_wave_gen (3 channels, 8-bit counters).
module tb_multi_wave_gen;
    import multi_wave_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
    logic [2:0] wave_out;
    logic [2:0] busy;
    logic       sync_pulse;

    int n_checks = 0;
    int n_errors = 0;

    multi_wave_gen #(.CHANNELS(3), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .wave_out   (wave_out),
        .busy       (busy),
        .sync_pulse (sync_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock with the given config inputs; returns 1 time unit after the edge.
    task automatic step(input logic we, input logic [1:0] ch, input logic [1:0] sel, input logic [7:0] data);
        cfg_we   = we;
        cfg_ch   = ch;
        cfg_sel  = sel;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic tick();
        step(1'b0, 2'd0, 2'd0, 8'd0);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [7:0] data);
        step(1'b1, ch, sel, data);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_sel = 2'd0; cfg_data = 8'd0;
        tick();
        tick();
        check_eq("rst_wave", wave_out, 32'd0);
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_sync", sync_pulse, 32'd0);
        rst = 1'b0;

        // 1: ch0 period 10 high 3 phase 0
        wr(2'd0, CFG_PERIOD, 8'd10);
        wr(2'd0, CFG_HIGH, 8'd3);
        wr(2'd0, CFG_PHASE, 8'd0);
        enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            check_eq("t1_wave", wave_out, ((k % 10) < 3) ? 32'd1 : 32'd0);
            check_eq("t1_sync", sync_pulse, ((k % 10 == 0) && (k > 0)) ? 32'd1 : 32'd0);
            check_eq("t1_busy", busy, 32'd1);
        end
        enable = 1'b0;
        tick();
        check_eq("t1_stop", {busy, wave_out}, 32'd0);

        // 2: ch1 period 8 high 4 phase 6
        wr(2'd1, CFG_PERIOD, 8'd8);
        wr(2'd1, CFG_HIGH, 8'd4);
        wr(2'd1, CFG_PHASE, 8'd6);
        enable = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick();
            check_eq("t2_wave1", wave_out[1], (((6 + k) % 8) < 4) ? 32'd1 : 32'd0);
            check_eq("t2_busy1", busy[1], 32'd1);
        end
        enable = 1'b0;
        tick();

        // 3: ch2 one-shot period 5 high 2, then re-trigger via enable 0->1
        wr(2'd2, CFG_MODE, 8'd1);
        wr(2'd2, CFG_PERIOD, 8'd5);
        wr(2'd2, CFG_HIGH, 8'd2);
        for (int r = 0; r < 2; r++) begin
            enable = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                check_eq("t3_wave2", wave_out[2], (k < 2) ? 32'd1 : 32'd0);
                check_eq("t3_busy2", busy[2], (k < 5) ? 32'd1 : 32'd0);
            end
            enable = 1'b0;
            tick();
            check_eq("t3_off_busy2", busy[2], 32'd0);
        end

        // 4: period change mid-period (takes effect at wrap) and a write on the wrap cycle
        enable = 1'b1;
        for (int k = 0; k < 23; k++) begin
            step((k == 3) || (k == 14), 2'd0, CFG_PERIOD, (k == 3) ? 8'd4 : 8'd6);
            if (k < 10)      cnt = k;
            else if (k < 14) cnt = k - 10;
            else             cnt = (k - 14) % 6;
            check_eq("t4_wave0", wave_out[0], (cnt < 3) ? 32'd1 : 32'd0);
            check_eq("t4_sync", sync_pulse, ((k == 10) || (k == 14) || (k == 20)) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;
        tick();

        // 5: invert with high 0 -> constant 1; high >= period -> constant 1; period 1 on ch0
        wr(2'd1, CFG_HIGH, 8'd0);
        wr(2'd1, CFG_MODE, 8'd2);
        check_eq("t5_idle_inv", wave_out[1], 32'd1);
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t5_inv_wave1", wave_out[1], 32'd1);
            check_eq("t5_inv_busy1", busy[1], 32'd1);
        end
        enable = 1'b0;
        tick();
        wr(2'd1, CFG_MODE, 8'd0);
        check_eq("t5_idle_noinv", wave_out[1], 32'd0);
        wr(2'd1, CFG_PERIOD, 8'd20);
        wr(2'd1, CFG_HIGH, 8'd255);
        wr(2'd0, CFG_PERIOD, 8'd1);
        wr(2'd0, CFG_HIGH, 8'd1);
        enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            check_eq("t5_full_wave1", wave_out[1], 32'd1);
            check_eq("t5_p1_wave0", wave_out[0], 32'd1);
            check_eq("t5_p1_sync", sync_pulse, (k >= 1) ? 32'd1 : 32'd0);
        end

        // 6: reset mid-run, then nothing runs with period 0; out-of-range channel ignored
        rst = 1'b1;
        tick();
        check_eq("t6_rst_wave", wave_out, 32'd0);
        check_eq("t6_rst_busy", busy, 32'd0);
        check_eq("t6_rst_sync", sync_pulse, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t6_idle", {sync_pulse, busy, wave_out}, 32'd0);
        end
        wr(2'd3, CFG_PERIOD, 8'd5);
        wr(2'd3, CFG_MODE, 8'd2);
        tick();
        check_eq("t6_badch_busy", busy, 32'd0);
        check_eq("t6_badch_wave", wave_out, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
